// File: rtl/id_stage_if.sv
// -----------------------------------------------------------------------------
// id_stage_if
//   Handshake bundle around the NPC instruction-decode stage. It carries
//   the fetch-side input (instruction, PC, valid/ready, flush) and the
//   ID/EX-side output (registered decode result, valid/ready).
//
//   Parameters
//     XLEN   datapath width (32 or 64)
//     RF_AW  register-file address width
//
//   Modports
//     master  the decode stage: consumes fetch inputs and out_ready,
//             drives in_ready and the ID/EX register contents
//     slave   the surrounding pipeline (fetch + EX side)
// -----------------------------------------------------------------------------
interface id_stage_if #(
  parameter int XLEN  = 64,
  parameter int RF_AW = 5
);
  // fetch -> ID
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst_i;
  logic [XLEN-1:0]  inst_addr_i;
  logic             flush_i;

  // ID -> EX
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      inst_o;
  logic [XLEN-1:0]  inst_addr_o;
  logic [XLEN-1:0]  op1_o;
  logic [XLEN-1:0]  op2_o;
  logic [3:0]       alu_op_o;
  logic             reg_we_o;
  logic [RF_AW-1:0] reg_waddr_o;
  logic             illegal_o;

  modport master (
    input  in_valid, inst_i, inst_addr_i, flush_i, out_ready,
    output in_ready, out_valid, inst_o, inst_addr_o, op1_o, op2_o,
           alu_op_o, reg_we_o, reg_waddr_o, illegal_o
  );

  modport slave (
    output in_valid, inst_i, inst_addr_i, flush_i, out_ready,
    input  in_ready, out_valid, inst_o, inst_addr_o, op1_o, op2_o,
           alu_op_o, reg_we_o, reg_waddr_o, illegal_o
  );
endinterface

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
//   Registered instruction-decode stage of the NPC core. Decodes the
//   RV32I/RV64I integer ALU subset (OP-IMM, OP, LUI, AUIPC) into two ALU
//   operands and an ALU opcode, and holds the result in an ID/EX register
//   under a valid/ready handshake. Register-file read addresses and enables
//   are driven combinationally from the incoming instruction; the RF returns
//   data in the same cycle and the operands are sampled at the accept edge.
//
//   Parameters
//     XLEN   datapath width, 32 or 64
//     RF_AW  register-file address width
//
//   Ports
//     clk, rst                  clock, asynchronous active-high reset
//     bus (id_stage_if.master)  fetch handshake in, ID/EX register out
//     reg{1,2}_raddr_o/read_o   combinational RF read address / enable
//     reg{1,2}_rdata_i          RF read data (same cycle)
//     ex_we_i/waddr_i/wdata_i   EX-stage result, used for bypassing
//
//   Build option
//     ID_BYPASS_EN  when defined, a source whose address matches the EX
//                   destination (non-zero, EX writing, source read) takes
//                   ex_wdata_i instead of the RF data. When undefined the
//                   ex_* ports are present but ignored.
// -----------------------------------------------------------------------------
module id_stage #(
  parameter int XLEN  = 64,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  id_stage_if.master       bus,
  output logic [RF_AW-1:0] reg1_raddr_o,
  output logic [RF_AW-1:0] reg2_raddr_o,
  output logic             reg1_read_o,
  output logic             reg2_read_o,
  input  logic [XLEN-1:0]  reg1_rdata_i,
  input  logic [XLEN-1:0]  reg2_rdata_i,
  input  logic             ex_we_i,
  input  logic [RF_AW-1:0] ex_waddr_i,
  input  logic [XLEN-1:0]  ex_wdata_i
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic [31:0]      inst;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    alu_op_e          alu_op;
    logic             we;
    logic [RF_AW-1:0] waddr;
    logic             illegal;
  } idex_t;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = bus.inst_i[6:0];
  assign rd     = bus.inst_i[11:7];
  assign funct3 = bus.inst_i[14:12];
  assign rs1    = bus.inst_i[19:15];
  assign rs2    = bus.inst_i[24:20];
  assign funct7 = bus.inst_i[31:25];

  // ---------------------------------------------------------------------------
  // Immediates, all extended to XLEN
  // ---------------------------------------------------------------------------
  logic signed [11:0] imm_i12;
  logic signed [31:0] imm_u32;
  logic [XLEN-1:0]    imm_i;
  logic [XLEN-1:0]    imm_u;
  logic [XLEN-1:0]    imm_sh;
  logic               shamt_ok;
  logic               shift_hi_zero;

  assign imm_i12 = bus.inst_i[31:20];
  assign imm_u32 = {bus.inst_i[31:12], 12'b0};
  // Size casts of signed values sign-extend; shamt is unsigned so it zero-extends.
  assign imm_i   = XLEN'(imm_i12);
  assign imm_u   = XLEN'(imm_u32);
  assign imm_sh  = XLEN'(bus.inst_i[25:20]);

  // A 6-bit shamt only exists on RV64; on RV32 shamt[5] set is reserved.
  assign shamt_ok      = (XLEN == 64) || !bus.inst_i[25];
  assign shift_hi_zero = (bus.inst_i[31:26] == 6'b000000);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic            illegal;
  logic            use_rs1;
  logic            use_rs2;
  logic            op1_pc;
  logic [XLEN-1:0] imm;
  alu_op_e         alu_op;

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path can leave one unassigned and infer a latch.
    illegal = 1'b1;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    op1_pc  = 1'b0;
    imm     = '0;
    alu_op  = ALU_ADD;

    case (opcode)
      OPC_OP_IMM: begin
        illegal = 1'b0;
        use_rs1 = 1'b1;
        imm     = imm_i;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          3'b001: begin
            alu_op  = ALU_SLL;
            imm     = imm_sh;
            illegal = !shift_hi_zero || !shamt_ok;
          end
          3'b101: begin
            // inst[30] is the only bit that separates SRAI from SRLI once the
            // remaining high bits have been checked.
            alu_op  = bus.inst_i[30] ? ALU_SRA : ALU_SRL;
            imm     = imm_sh;
            illegal = !(shift_hi_zero || (bus.inst_i[31:26] == 6'b010000)) || !shamt_ok;
          end
        endcase
      end

      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (funct7 == F7_BASE) begin
          illegal = 1'b0;
          case (funct3)
            3'b000: alu_op = ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = ALU_SRL;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          illegal = 1'b0;
          alu_op  = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          illegal = 1'b0;
          alu_op  = ALU_SRA;
        end
      end

      OPC_LUI: begin
        illegal = 1'b0;
        imm     = imm_u;
      end

      OPC_AUIPC: begin
        illegal = 1'b0;
        op1_pc  = 1'b1;
        imm     = imm_u;
      end

      default: ;
    endcase

    // Unsupported encodings present a fully neutral decode: no RF reads,
    // zero operands, ADD.
    if (illegal) begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      op1_pc  = 1'b0;
      imm     = '0;
      alu_op  = ALU_ADD;
    end
  end

  // ---------------------------------------------------------------------------
  // Register-file read ports (independent of in_valid)
  // ---------------------------------------------------------------------------
  assign reg1_read_o  = use_rs1;
  assign reg2_read_o  = use_rs2;
  assign reg1_raddr_o = use_rs1 ? RF_AW'(rs1) : '0;
  assign reg2_raddr_o = use_rs2 ? RF_AW'(rs2) : '0;

  // ---------------------------------------------------------------------------
  // Source operand values
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

`ifdef ID_BYPASS_EN
  // x0 is never forwarded: it reads as zero regardless of what EX claims.
  logic byp1;
  logic byp2;

  assign byp1 = ex_we_i && reg1_read_o && (reg1_raddr_o != '0) && (ex_waddr_i == reg1_raddr_o);
  assign byp2 = ex_we_i && reg2_read_o && (reg2_raddr_o != '0) && (ex_waddr_i == reg2_raddr_o);

  assign rs1_val = byp1 ? ex_wdata_i : reg1_rdata_i;
  assign rs2_val = byp2 ? ex_wdata_i : reg2_rdata_i;
`else
  // The EX result ports stay on the boundary so both builds share one
  // pinout; without forwarding they have no load.
  logic unused_ex;

  assign unused_ex = ^{ex_we_i, ex_waddr_i, ex_wdata_i};
  assign rs1_val   = reg1_rdata_i;
  assign rs2_val   = reg2_rdata_i;
`endif

  // ---------------------------------------------------------------------------
  // Next ID/EX contents
  // ---------------------------------------------------------------------------
  idex_t idex_d;
  logic  rd_we;

  // Writes to x0 are dropped here so EX never sees a write-back to x0.
  assign rd_we = !illegal && (rd != 5'd0);

  always_comb begin
    idex_d         = '0;
    idex_d.inst    = bus.inst_i;
    idex_d.pc      = bus.inst_addr_i;
    idex_d.op1     = use_rs1 ? rs1_val : (op1_pc ? bus.inst_addr_i : '0);
    idex_d.op2     = use_rs2 ? rs2_val : imm;
    idex_d.alu_op  = alu_op;
    idex_d.we      = rd_we;
    idex_d.waddr   = rd_we ? RF_AW'(rd) : '0;
    idex_d.illegal = illegal;
  end

  // ---------------------------------------------------------------------------
  // Handshake and pipeline register
  // ---------------------------------------------------------------------------
  idex_t idex_q;
  logic  out_valid_q;
  logic  accept;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      idex_q      <= '0;
    end else if (bus.flush_i) begin
      // Flush drops both the held and the incoming instruction; the data
      // registers keep their old contents behind the cleared valid.
      out_valid_q <= 1'b0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register here samples pre-edge values regardless of statement order.
      out_valid_q <= 1'b1;
      idex_q      <= idex_d;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.inst_o      = idex_q.inst;
  assign bus.inst_addr_o = idex_q.pc;
  assign bus.op1_o       = idex_q.op1;
  assign bus.op2_o       = idex_q.op2;
  assign bus.alu_op_o    = idex_q.alu_op;
  assign bus.reg_we_o    = idex_q.we;
  assign bus.reg_waddr_o = idex_q.waddr;
  assign bus.illegal_o   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
//   Scoreboard bench for id_stage. Two instances are built: XLEN=64 and
//   XLEN=32. Stimulus tasks push the hand-computed expected ID/EX contents
//   into a per-instance queue when an instruction is accepted; a monitor per
//   instance compares the presented output against the queue head every
//   cycle out_valid is high and pops it when EX accepts.
// -----------------------------------------------------------------------------
module tb_id_stage;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [3:0]  alu;
    logic        we;
    logic [4:0]  waddr;
    logic        illegal;
  } out_t;

`ifdef ID_BYPASS_EN
  localparam logic [63:0] BYP_EXP = 64'h55;
`else
  localparam logic [63:0] BYP_EXP = 64'h11;
`endif

  logic clk;
  logic rst;

  logic [63:0] rd1_v;
  logic [63:0] rd2_v;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [63:0] ex_wdata;

  logic [4:0] ra1_64, ra2_64, ra1_32, ra2_32;
  logic       re1_64, re2_64, re1_32, re2_32;

  int checks   = 0;
  int failures = 0;

  out_t q64[$];
  out_t q32[$];

  id_stage_if #(.XLEN(64), .RF_AW(5)) bus64 ();
  id_stage_if #(.XLEN(32), .RF_AW(5)) bus32 ();

  id_stage #(.XLEN(64), .RF_AW(5)) dut64 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus64),
    .reg1_raddr_o (ra1_64),
    .reg2_raddr_o (ra2_64),
    .reg1_read_o  (re1_64),
    .reg2_read_o  (re2_64),
    .reg1_rdata_i (rd1_v),
    .reg2_rdata_i (rd2_v),
    .ex_we_i      (ex_we),
    .ex_waddr_i   (ex_waddr),
    .ex_wdata_i   (ex_wdata)
  );

  id_stage #(.XLEN(32), .RF_AW(5)) dut32 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus32),
    .reg1_raddr_o (ra1_32),
    .reg2_raddr_o (ra2_32),
    .reg1_read_o  (re1_32),
    .reg2_read_o  (re2_32),
    .reg1_rdata_i (rd1_v[31:0]),
    .reg2_rdata_i (rd2_v[31:0]),
    .ex_we_i      (ex_we),
    .ex_waddr_i   (ex_waddr),
    .ex_wdata_i   (ex_wdata[31:0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic out_t mk(input logic [31:0] inst, input logic [63:0] pc, op1, op2,
                              input logic [3:0] alu, input logic we, input logic [4:0] wa,
                              input logic ill);
    out_t r;
    r.inst    = inst;
    r.pc      = pc;
    r.op1     = op1;
    r.op2     = op2;
    r.alu     = alu;
    r.we      = we;
    r.waddr   = wa;
    r.illegal = ill;
    return r;
  endfunction

  task automatic cmp_entry(input string tag, input out_t act, input out_t exp);
    check({tag, ".inst"},    64'(act.inst),    64'(exp.inst));
    check({tag, ".pc"},      act.pc,           exp.pc);
    check({tag, ".op1"},     act.op1,          exp.op1);
    check({tag, ".op2"},     act.op2,          exp.op2);
    check({tag, ".alu_op"},  64'(act.alu),     64'(exp.alu));
    check({tag, ".we"},      64'(act.we),      64'(exp.we));
    check({tag, ".waddr"},   64'(act.waddr),   64'(exp.waddr));
    check({tag, ".illegal"}, 64'(act.illegal), 64'(exp.illegal));
  endtask

  // Drive one instruction into the selected instance, check its combinational
  // RF read outputs, and push the expected ID/EX contents on acceptance.
  task automatic issue(input bit to32, input logic [31:0] inst, input logic [63:0] pc,
                       input logic [63:0] rd1, rd2, e_op1, e_op2, input logic [3:0] e_alu,
                       input logic e_we, input logic [4:0] e_wa, input logic e_ill,
                       input logic [4:0] c1, input logic r1, input logic [4:0] c2,
                       input logic r2);
    int    n;
    string t;
    out_t  e;
    logic  rdy;
    t = to32 ? "x32" : "x64";
    e = mk(inst, pc, e_op1, e_op2, e_alu, e_we, e_wa, e_ill);
    bus64.inst_i      = inst;
    bus32.inst_i      = inst;
    bus64.inst_addr_i = pc;
    bus32.inst_addr_i = pc[31:0];
    rd1_v = rd1;
    rd2_v = rd2;
    if (to32) bus32.in_valid = 1'b1;
    else      bus64.in_valid = 1'b1;
    @(negedge clk);
    check({t, ".raddr1"}, 64'(to32 ? ra1_32 : ra1_64), 64'(c1));
    check({t, ".read1"},  64'(to32 ? re1_32 : re1_64), 64'(r1));
    check({t, ".raddr2"}, 64'(to32 ? ra2_32 : ra2_64), 64'(c2));
    check({t, ".read2"},  64'(to32 ? re2_32 : re2_64), 64'(r2));
    n   = 0;
    rdy = to32 ? bus32.in_ready : bus64.in_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
      rdy = to32 ? bus32.in_ready : bus64.in_ready;
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL %s.accept_timeout: in_ready stayed 0, expected 1 within 20 cycles", t);
      bus64.in_valid = 1'b0;
      bus32.in_valid = 1'b0;
    end else if (to32) begin
      q32.push_back(e);
    end else begin
      q64.push_back(e);
    end
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
    bus32.in_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && bus64.out_valid) begin
      if (q64.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon64.unexpected: out_valid=1 with inst 0x%0h, expected no output", bus64.inst_o);
      end else begin
        cmp_entry("mon64", mk(bus64.inst_o, bus64.inst_addr_o, bus64.op1_o, bus64.op2_o,
                              bus64.alu_op_o, bus64.reg_we_o, bus64.reg_waddr_o,
                              bus64.illegal_o), q64[0]);
        if (bus64.out_ready) void'(q64.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus32.out_valid) begin
      if (q32.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon32.unexpected: out_valid=1 with inst 0x%0h, expected no output", bus32.inst_o);
      end else begin
        cmp_entry("mon32", mk(bus32.inst_o, 64'(bus32.inst_addr_o), 64'(bus32.op1_o),
                              64'(bus32.op2_o), bus32.alu_op_o, bus32.reg_we_o,
                              bus32.reg_waddr_o, bus32.illegal_o), q32[0]);
        if (bus32.out_ready) void'(q32.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, ".out_valid"},   64'(bus64.out_valid),   64'd0);
    check({tag, ".inst_o"},      64'(bus64.inst_o),      64'd0);
    check({tag, ".inst_addr_o"}, bus64.inst_addr_o,      64'd0);
    check({tag, ".op1_o"},       bus64.op1_o,            64'd0);
    check({tag, ".op2_o"},       bus64.op2_o,            64'd0);
    check({tag, ".alu_op_o"},    64'(bus64.alu_op_o),    64'd0);
    check({tag, ".reg_we_o"},    64'(bus64.reg_we_o),    64'd0);
    check({tag, ".reg_waddr_o"}, 64'(bus64.reg_waddr_o), 64'd0);
    check({tag, ".illegal_o"},   64'(bus64.illegal_o),   64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    bus64.in_valid = 1'b0; bus64.flush_i = 1'b0; bus64.out_ready = 1'b1;
    bus64.inst_i = '0;     bus64.inst_addr_i = '0;
    bus32.in_valid = 1'b0; bus32.flush_i = 1'b0; bus32.out_ready = 1'b1;
    bus32.inst_i = '0;     bus32.inst_addr_i = '0;
    rd1_v = '0; rd2_v = '0; ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0;

    #1;
    check_zero_outputs("reset_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset.in_ready", 64'(bus64.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Decode sweep, back to back at full throughput (XLEN=64).
    //     to32 inst          pc            rd1     rd2     op1                    op2                    alu we wa ill c1 r1 c2 r2
    issue(0, 32'hFFF08293, 64'h1000,     64'd10, 64'd0,  64'd10,                64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 5, 0, 1, 1, 0, 0); // ADDI x5,x1,-1
    issue(0, 32'h4281D193, 64'h1004,     64'h123, 64'd0, 64'h123,               64'd40,                7, 1, 3, 0, 3, 1, 0, 0); // SRAI x3,x3,40
    issue(0, 32'h12345037, 64'h1008,     64'd1,  64'd2,  64'd0,                 64'h1234_5000,         0, 0, 0, 0, 0, 0, 0, 0); // LUI x0
    issue(0, 32'h80000237, 64'h100C,     64'd1,  64'd2,  64'd0,                 64'hFFFF_FFFF_8000_0000, 0, 1, 4, 0, 0, 0, 0, 0); // LUI x4,0x80000
    issue(0, 32'hFFFFFFFF, 64'h1010,     64'h77, 64'h88, 64'd0,                 64'd0,                 0, 0, 0, 1, 0, 0, 0, 0); // opcode 0x7F
    issue(0, 32'h00001517, 64'h8000_0000, 64'd3, 64'd4,  64'h8000_0000,         64'h1000,              0, 1, 10, 0, 0, 0, 0, 0); // AUIPC x10,1
    issue(0, 32'h403100B3, 64'h1018,     64'd7,  64'd9,  64'd7,                 64'd9,                 1, 1, 1, 0, 2, 1, 3, 1); // SUB x1,x2,x3
    issue(0, 32'h023100B3, 64'h101C,     64'd7,  64'd9,  64'd0,                 64'd0,                 0, 0, 0, 1, 0, 0, 0, 0); // MUL: illegal
    issue(0, 32'h03F39313, 64'h1020,     64'd1,  64'd0,  64'd1,                 64'd63,                2, 1, 6, 0, 7, 1, 0, 0); // SLLI x6,x7,63
    issue(0, 32'h7FF4B413, 64'h1024,     64'd5,  64'd0,  64'd5,                 64'h7FF,               4, 1, 8, 0, 9, 1, 0, 0); // SLTIU x8,x9,0x7FF
    issue(0, 32'h403150B3, 64'h1028,     64'hF0, 64'd4,  64'hF0,                64'd4,                 7, 1, 1, 0, 2, 1, 3, 1); // SRA x1,x2,x3
    issue(0, 32'h07F39313, 64'h102C,     64'd1,  64'd0,  64'd0,                 64'd0,                 0, 0, 0, 1, 0, 0, 0, 0); // SLLI bad funct6
    issue(0, 32'h0F016113, 64'h1030,     64'd3,  64'd0,  64'd3,                 64'hF0,                8, 1, 2, 0, 2, 1, 0, 0); // ORI x2,x2,0xF0

    // Drain, then backpressure: A held for three cycles while B waits.
    @(posedge clk); #1;
    bus64.out_ready = 1'b0;
    issue(0, 32'h00108093, 64'h1100, 64'd20, 64'd0, 64'd20, 64'd1, 0, 1, 1, 0, 1, 1, 0, 0);   // ADDI x1,x1,1
    fork
      issue(0, 32'h00208113, 64'h1104, 64'd30, 64'd0, 64'd30, 64'd2, 0, 1, 2, 0, 1, 1, 0, 0); // ADDI x2,x1,2
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall.in_ready", 64'(bus64.in_ready), 64'd0);
          @(posedge clk);
        end
        #1;
        bus64.out_ready = 1'b1;
      end
    join
    @(posedge clk); #1;

    // Flush with a held instruction and a valid incoming one.
    bus64.out_ready = 1'b0;
    issue(0, 32'h00500193, 64'h1200, 64'd0, 64'd0, 64'd0, 64'd5, 0, 1, 3, 0, 0, 1, 0, 0);     // ADDI x3,x0,5
    bus64.out_ready   = 1'b1;
    bus64.inst_i      = 32'h00600213;                                                          // ADDI x4,x0,6
    bus64.inst_addr_i = 64'h1204;
    bus64.in_valid    = 1'b1;
    bus64.flush_i     = 1'b1;
    @(posedge clk);
    q64.delete();
    #1;
    bus64.flush_i  = 1'b0;
    bus64.in_valid = 1'b0;
    check("flush.out_valid", 64'(bus64.out_valid), 64'd0);
    check("flush.inst_hold", 64'(bus64.inst_o), 64'h0050_0193);
    @(posedge clk); #1;
    check("flush.no_load", 64'(bus64.out_valid), 64'd0);

    // Forwarding from EX.
    ex_we = 1'b1; ex_waddr = 5'd2; ex_wdata = 64'h55;
    issue(0, 32'h002103B3, 64'h2000, 64'h11, 64'h11, BYP_EXP, BYP_EXP, 0, 1, 7, 0, 2, 1, 2, 1); // ADD x7,x2,x2
    issue(0, 32'h003103B3, 64'h2004, 64'h11, 64'h33, BYP_EXP, 64'h33,  0, 1, 7, 0, 2, 1, 3, 1); // ADD x7,x2,x3
    ex_waddr = 5'd0;
    issue(0, 32'h000003B3, 64'h2008, 64'h22, 64'h22, 64'h22,  64'h22,  0, 1, 7, 0, 0, 1, 0, 1); // ADD x7,x0,x0
    ex_we = 1'b0; ex_wdata = '0;

    // XLEN=32 instance.
    issue(1, 32'h4281D193, 64'h3000, 64'h123, 64'd0, 64'd0,  64'd0,          0, 0, 0, 1, 0, 0, 0, 0); // SRAI 40: illegal
    issue(1, 32'hFFF08293, 64'h3004, 64'd10,  64'd0, 64'd10, 64'hFFFF_FFFF,  0, 1, 5, 0, 1, 1, 0, 0); // ADDI x5,x1,-1
    issue(1, 32'h80000237, 64'h3008, 64'd0,   64'd0, 64'd0,  64'h8000_0000,  0, 1, 4, 0, 0, 0, 0, 0); // LUI x4,0x80000
    issue(1, 32'h01F0D093, 64'h300C, 64'd5,   64'd0, 64'd5,  64'd31,         6, 1, 1, 0, 1, 1, 0, 0); // SRLI x1,x1,31
    issue(1, 32'h03F39313, 64'h3010, 64'd1,   64'd0, 64'd0,  64'd0,          0, 0, 0, 1, 0, 0, 0, 0); // SLLI 63: illegal
    repeat (2) @(posedge clk); #1;

    // Reset while an instruction is held.
    bus64.out_ready = 1'b0;
    issue(0, 32'h00A00293, 64'h4000, 64'd0, 64'd0, 64'd0, 64'd10, 0, 1, 5, 0, 0, 1, 0, 0);     // ADDI x5,x0,10
    @(negedge clk);
    #2;
    rst = 1'b1;
    q64.delete();
    #1;
    check_zero_outputs("reset_mid");
    bus64.out_ready = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("reset_mid.in_ready", 64'(bus64.in_ready), 64'd1);
    repeat (3) @(posedge clk); #1;

    check("q64.drained", 64'(q64.size()), 64'd0);
    check("q32.drained", 64'(q32.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Registered, parametrised instruction-decode stage for the NPC core. It sits between the IF/ID fetch output and EX and drives combinational register-file read addresses. It decodes the RV64I/RV32I integer ALU subset (OP-IMM, OP, LUI, AUIPC) into ALU operands and an ALU opcode, and holds the result in an ID/EX pipeline register under a valid/ready handshake, with flush and optional EX→ID bypass.

## Interface
- `XLEN`, 64, datapath width; legal values 32 or 64.
- `RF_AW`, 5, register-file address width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `inst_i`/`inst_addr_i` valid.
- `in_ready`  out  1  stage can accept; `!out_valid || out_ready`.
- `inst_i`  in  32  instruction.
- `inst_addr_i`  in  XLEN  instruction PC.
- `flush_i`  in  1  discard held and incoming instruction.
- `reg1_raddr_o`, `reg2_raddr_o`  out  RF_AW  combinational RF read addresses.
- `reg1_read_o`, `reg2_read_o`  out  1  combinational read enables.
- `reg1_rdata_i`, `reg2_rdata_i`  in  XLEN  RF read data, same cycle.
- `ex_we_i`  in  1  EX result will be written.
- `ex_waddr_i`  in  RF_AW  EX destination.
- `ex_wdata_i`  in  XLEN  EX result.
- `out_valid`  out  1  ID/EX register holds an instruction.
- `out_ready`  in  1  EX accepts.
- `inst_o`  out  32  registered instruction.
- `inst_addr_o`  out  XLEN  registered PC.
- `op1_o`, `op2_o`  out  XLEN  registered operands.
- `alu_op_o`  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9.
- `reg_we_o`  out  1  registered write-back enable.
- `reg_waddr_o`  out  RF_AW  registered rd.
- `illegal_o`  out  1  registered: instruction not in supported subset.

## Operation
- Combinational decode from `inst_i`: `reg1_raddr_o`=rs1 when used, else 0; `reg2_raddr_o`=rs2 for OP, else 0. Read enables match. Outputs are independent of `in_valid`.
- OP-IMM (0010011): op1=rs1, op2=sext(inst[31:20]). funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
- OP-IMM shifts: 001 SLLI requires inst[31:26]=0. 101 requires inst[31:26]=000000 (SRL) or 010000 (SRA). op2=zero-extended shamt (inst[25:20]). When XLEN=32, inst[25]=1 is illegal.
- OP (0110011): op2=rs2. funct7=0000000 gives ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3. funct7=0100000 with funct3 000→SUB, 101→SRA. Other funct7 values are illegal.
- LUI (0110111): op1=0, op2=sext({inst[31:12],12'b0}), ADD.
- AUIPC (0010111): op1=`inst_addr_i`, op2 as LUI, ADD.
- Illegal/unsupported: `illegal_o`=1, `reg_we_o`=0, `reg_waddr_o`=0, operands 0, `alu_op_o`=ADD, read enables 0.
- rd=x0: `reg_we_o`=0, `reg_waddr_o`=0, instruction otherwise normal.
- Sign extension is to XLEN; all arithmetic widths are XLEN.

## Timing
- Reset (async, immediate): `out_valid`=0, `inst_o`=0, `inst_addr_o`=0, `op1_o`=`op2_o`=0, `alu_op_o`=0, `reg_we_o`=0, `reg_waddr_o`=0, `illegal_o`=0.
- Latency: 1 cycle. The instruction accepted at edge N appears on outputs after edge N.
- Accept = `in_valid && in_ready && !flush_i`. On accept, load all registers and set `out_valid`=1.
- If `out_valid && out_ready` and there is no accept, clear `out_valid`. Data registers hold.
- If `out_valid && !out_ready`, all registers hold and `in_ready`=0. Back-to-back accept at full throughput when `out_ready`=1.
- `flush_i` wins over everything: next edge `out_valid`=0, with no load.
- Operands are sampled at the accept edge. The RF must supply data combinationally in the same cycle.

## Configuration
- `ID_BYPASS_EN` defined: when `ex_we_i && ex_waddr_i==rsN && rsN!=0 && regN_read_o`, the operand uses `ex_wdata_i` instead of `regN_rdata_i`, independently per source.
- `ID_BYPASS_EN` undefined: `ex_*` ports are present but ignored, and operands always come from the RF.

## Test plan
- Reset mid-stream: assert `rst` with `out_valid`=1 → all outputs 0 immediately. After release, `in_ready`=1.
- ADDI x5,x1,-1 (0xFFF08293), rdata1=10, XLEN=64 → one cycle later: op1=10, op2=0xFFFF_FFFF_FFFF_FFFF, alu_op=0, we=1, waddr=5.
- Backpressure: two valid instrs, `out_ready`=0 for 3 cycles → first held stable, `in_ready`=0. Second is accepted on the cycle `out_ready` rises; no loss or duplication.
- Flush while `in_valid`=1 and `out_valid`=1 → next cycle `out_valid`=0, and the incoming instruction is not loaded.
- Decode sweep: SRAI x3,x3,40 → alu_op=7, op2=40 (XLEN=64). The same encoding at XLEN=32 → illegal_o=1. LUI x0,... → we=0. Opcode 0x7F → illegal_o=1.
- Bypass (macro on): ADD x7,x2,x2 with ex_we=1, ex_waddr=2, ex_wdata=0x55, rdata=0x11 → op1=op2=0x55. Macro off → 0x11. ex_waddr=0 → never bypassed.
